stage2: RTL

Decode/operand-read stage of the five-stage processor; sits directly downstream of stage 1 and consumes its `ir2`/`pc2` outputs. It holds the 32x32 general register file and decodes the instruction into source fields, destination field and sign-extended immediate. It detects load-use hazards and drives the `pause1`/`pause2`/`nop2` controls back into stage 1. It latches operands and control for stage 3 at each clock.

---
 rtl/stage2.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/stage2.sv
// -----------------------------------------------------------------------------
// stage2 : decode / operand-read stage of the five-stage pipeline.
//
// Holds the 32-entry general register file and decodes ir2 into source
// fields, a destination field and a sign-extended immediate. It detects
// load-use hazards against the instruction already in stage 3 and drives
// the hold/flush controls back into stage 1. Operands and control are
// registered into stage 3 on every rising edge.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   clr      in   synchronous active-high reset
//   ir2      in   instruction from stage 1
//   pc2      in   PC+4 of ir2
//   mp1      in   flush request (taken branch / mispredict) from stage 4
//   wb_en    in   register-file write enable from writeback
//   wb_addr  in   register-file write address
//   wb_data  in   register-file write data
//   ir3      out  instruction to stage 3
//   pc3      out  PC+4 to stage 3
//   a3       out  operand read from rs
//   b3       out  operand read from rt
//   imm3     out  sign-extended ir2[15:0]
//   dst3     out  destination register number, 0 if none
//   ld3      out  stage-3 instruction is a load
//   pause1   out  hold PC in stage 1 (combinational)
//   pause2   out  hold ir2/pc2 in stage 1 (combinational)
//   nop2     out  replace ir2 with a NOP next cycle (combinational)
// -----------------------------------------------------------------------------
module stage2 #(
    parameter int WIDTH = 32,
    parameter int DLY   = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir2,
    input  logic [WIDTH-1:0] pc2,
    input  logic             mp1,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [31:0]      ir3,
    output logic [WIDTH-1:0] pc3,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] b3,
    output logic [WIDTH-1:0] imm3,
    output logic [4:0]       dst3,
    output logic             ld3,
    output logic             pause1,
    output logic             pause2,
    output logic             nop2
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // DLY describes the clock-to-output timing of the stage-3 registers for
    // timing-annotated models; the synthesizable logic itself carries no delay.
    if (DLY >= 0) begin : g_dly_zero_in_rtl
    end

    logic [WIDTH-1:0] r_rf [32];

    logic [31:0]      r_ir3;
    logic [WIDTH-1:0] r_pc3;
    logic [WIDTH-1:0] r_a3;
    logic [WIDTH-1:0] r_b3;
    logic [WIDTH-1:0] r_imm3;
    logic [4:0]       r_dst3;
    logic             r_ld3;

    logic [5:0]       w_op;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic             w_rd_rt;
    logic             w_is_ld;
    logic [4:0]       w_dst;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_imm;
    logic             w_stall;
    logic             w_bubble;

    assign w_op  = ir2[31:26];
    assign w_rs  = ir2[25:21];
    assign w_rt  = ir2[20:16];
    assign w_rd  = ir2[15:11];
    assign w_imm = {{(WIDTH-16){ir2[15]}}, ir2[15:0]};

    // Every class reads rs; only R-type, SW and BEQ also read rt.
    always_comb begin
        w_rd_rt = 1'b0;
        w_is_ld = 1'b0;
        w_dst   = w_rt;
        case (w_op)
            OP_RTYPE: begin
                w_rd_rt = 1'b1;
                w_dst   = w_rd;
            end
            OP_LW: begin
                w_is_ld = 1'b1;
                w_dst   = w_rt;
            end
            OP_SW, OP_BEQ: begin
                w_rd_rt = 1'b1;
                w_dst   = 5'd0;
            end
            default: begin
                w_dst   = w_rt;
            end
        endcase
    end

    // Same-cycle writeback bypass; r0 is never written so it always reads 0.
    assign w_a = (wb_en && (wb_addr == w_rs) && (w_rs != 5'd0)) ? wb_data : r_rf[w_rs];
    assign w_b = (wb_en && (wb_addr == w_rt) && (w_rt != 5'd0)) ? wb_data : r_rf[w_rt];

    // Load-use: the load in stage 3 cannot forward its data in time.
    assign w_stall = r_ld3 && (r_dst3 != 5'd0) &&
                     ((r_dst3 == w_rs) || (w_rd_rt && (r_dst3 == w_rt)));

    // A flush overrides the stall: the held instruction is discarded anyway.
    assign pause1   = w_stall && !mp1;
    assign pause2   = w_stall && !mp1;
    assign nop2     = mp1;
    assign w_bubble = w_stall || mp1;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Stage 2 -> stage 3 boundary
    always_ff @(posedge clk) begin
        if (clr || w_bubble) begin
            r_ir3  <= '0;
            r_pc3  <= '0;
            r_a3   <= '0;
            r_b3   <= '0;
            r_imm3 <= '0;
            r_dst3 <= '0;
            r_ld3  <= 1'b0;
        end else begin
            r_ir3  <= ir2;
            r_pc3  <= pc2;
            r_a3   <= w_a;
            r_b3   <= w_b;
            r_imm3 <= w_imm;
            r_dst3 <= w_dst;
            r_ld3  <= w_is_ld;
        end
    end

    assign ir3  = r_ir3;
    assign pc3  = r_pc3;
    assign a3   = r_a3;
    assign b3   = r_b3;
    assign imm3 = r_imm3;
    assign dst3 = r_dst3;
    assign ld3  = r_ld3;

endmodule
